// File: rtl/load_store_unit_pkg.sv
// Shared encodings and helpers for the load/store unit: access sizes, FSM
// state codes and the latched request payload.
package load_store_unit_pkg;

    localparam int unsigned WORD_BYTES = 4;
    localparam int unsigned DATA_W     = 8 * WORD_BYTES;
    localparam int unsigned OFF_W      = $clog2(WORD_BYTES);
    localparam int unsigned SHAMT_W    = $clog2(DATA_W);
    localparam int unsigned SIZE_W     = 2;
    localparam int unsigned STATE_W    = 3;

    localparam logic [SIZE_W-1:0] SIZE_BYTE = 2'b00;
    localparam logic [SIZE_W-1:0] SIZE_HALF = 2'b01;
    localparam logic [SIZE_W-1:0] SIZE_WORD = 2'b10;
    localparam logic [SIZE_W-1:0] SIZE_RSVD = 2'b11;

    localparam logic [STATE_W-1:0] ST_IDLE    = 3'd0;
    localparam logic [STATE_W-1:0] ST_RD      = 3'd1;
    localparam logic [STATE_W-1:0] ST_LD_CAP  = 3'd2;
    localparam logic [STATE_W-1:0] ST_WR      = 3'd3;
    localparam logic [STATE_W-1:0] ST_RMW_RD  = 3'd4;
    localparam logic [STATE_W-1:0] ST_RMW_MRG = 3'd5;

    typedef struct packed {
        logic              write;
        logic [SIZE_W-1:0] size;
        logic              sgn;
        logic [DATA_W-1:0] store_data;
    } lsu_req_t;

    // Reserved size and unaligned half/word accesses are rejected at accept.
    function automatic logic misaligned(input logic [SIZE_W-1:0] size,
                                        input logic [OFF_W-1:0]  off);
        case (size)
            SIZE_BYTE: return 1'b0;
            SIZE_HALF: return off[0];
            SIZE_WORD: return off != 2'b00;
            default:   return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Datapath request/response and data-memory signals of the load/store unit.
interface load_store_unit_if #(
    parameter int unsigned ADDR_WIDTH = 10
);
    import load_store_unit_pkg::*;

    logic                    Req;
    logic                    Write;
    logic [SIZE_W-1:0]       Size;
    logic                    Signed;
    logic [ADDR_WIDTH+1:0]   Addr;
    logic [DATA_W-1:0]       StoreData;
    logic                    Ready;
    logic                    Done;
    logic                    AddrError;
    logic [DATA_W-1:0]       LoadData;
    logic [ADDR_WIDTH-1:0]   MemAddress;
    logic [DATA_W-1:0]       MemWriteData;
    logic                    MemRead;
    logic                    MemWrite;
    logic [DATA_W-1:0]       MemReadData;

    modport master (
        input  Req, Write, Size, Signed, Addr, StoreData, MemReadData,
        output Ready, Done, AddrError, LoadData,
               MemAddress, MemWriteData, MemRead, MemWrite
    );

    modport slave (
        output Req, Write, Size, Signed, Addr, StoreData, MemReadData,
        input  Ready, Done, AddrError, LoadData,
               MemAddress, MemWriteData, MemRead, MemWrite
    );

endinterface

// File: rtl/load_store_unit_lane_align.sv
// Byte-lane steering: extracts/extends load lanes and merges sub-word store
// data into a read word, for either byte order.
module load_store_unit_lane_align
    import load_store_unit_pkg::*;
#(
    parameter bit BIG_ENDIAN = 1'b1
) (
    input  logic [OFF_W-1:0]  offset,
    input  logic [SIZE_W-1:0] size,
    input  logic              sgn,
    input  logic [DATA_W-1:0] read_word,
    input  logic [DATA_W-1:0] store_data,
    output logic [DATA_W-1:0] load_value_c,
    output logic [DATA_W-1:0] merge_word_c
);

    logic [SHAMT_W-1:0] shamt;
    logic [DATA_W-1:0]  mask;
    logic [DATA_W-1:0]  lane;

    // Lane position: big-endian puts offset 0 in the most significant byte.
    always_comb begin
        shamt = '0;
        mask  = '1;
        case (size)
            SIZE_BYTE: begin
                shamt = BIG_ENDIAN ? {~offset, 3'b000} : {offset, 3'b000};
                mask  = DATA_W'(8'hFF) << shamt;
            end
            SIZE_HALF: begin
                shamt = BIG_ENDIAN ? {~offset[1], 4'b0000} : {offset[1], 4'b0000};
                mask  = DATA_W'(16'hFFFF) << shamt;
            end
            default: ;
        endcase
    end

    always_comb begin
        lane         = read_word >> shamt;
        load_value_c = lane;
        case (size)
            SIZE_BYTE: load_value_c = {{24{sgn & lane[7]}}, lane[7:0]};
            SIZE_HALF: load_value_c = {{16{sgn & lane[15]}}, lane[15:0]};
            default: ;
        endcase
        merge_word_c = (read_word & ~mask) | ((store_data << shamt) & mask);
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: byte/half/word accesses to a one-cycle-latency word memory,
// with read-modify-write for sub-word stores.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter bit          BIG_ENDIAN = 1'b1
) (
    input logic               Clock,
    input logic               Reset_n,
    load_store_unit_if.master bus
);

    logic [STATE_W-1:0]    state_q, state_d;
    lsu_req_t              req_q;
    logic [ADDR_WIDTH+1:0] addr_q;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic [DATA_W-1:0]     load_q, load_d;
    logic                  latch_c;
    logic [DATA_W-1:0]     load_value_c;
    logic [DATA_W-1:0]     merge_word_c;

    load_store_unit_lane_align #(.BIG_ENDIAN(BIG_ENDIAN)) u_lane (
        .offset       (addr_q[OFF_W-1:0]),
        .size         (req_q.size),
        .sgn          (req_q.sgn),
        .read_word    (bus.MemReadData),
        .store_data   (req_q.store_data),
        .load_value_c (load_value_c),
        .merge_word_c (merge_word_c)
    );

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= ST_IDLE;
            req_q   <= '0;
            addr_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            load_q  <= '0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            err_q   <= err_d;
            load_q  <= load_d;
            if (latch_c) begin
                req_q  <= '{write: bus.Write, size: bus.Size, sgn: bus.Signed,
                           store_data: bus.StoreData};
                addr_q <= bus.Addr;
            end
        end
    end

    // Misaligned requests complete from IDLE with an error pulse and no access.
    always_comb begin
        state_d = state_q;
        latch_c = 1'b0;
        done_d  = 1'b0;
        err_d   = 1'b0;
        load_d  = load_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.Req) begin
                    latch_c = 1'b1;
                    if (misaligned(bus.Size, bus.Addr[OFF_W-1:0])) begin
                        done_d = 1'b1;
                        err_d  = 1'b1;
                    end else if (!bus.Write) begin
                        state_d = ST_RD;
                    end else if (bus.Size == SIZE_WORD) begin
                        state_d = ST_WR;
                    end else begin
                        state_d = ST_RMW_RD;
                    end
                end
            end
            ST_RD:     state_d = ST_LD_CAP;
            ST_LD_CAP: begin
                load_d  = load_value_c;
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            ST_WR: begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            ST_RMW_RD: state_d = ST_RMW_MRG;
            ST_RMW_MRG: begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default:   state_d = ST_IDLE;
        endcase
    end

    // Memory strobes decode straight from state so reset drops them at once.
    assign bus.Ready        = (state_q == ST_IDLE);
    assign bus.Done         = done_q;
    assign bus.AddrError    = err_q;
    assign bus.LoadData     = load_q;
    assign bus.MemAddress   = addr_q[ADDR_WIDTH+1:OFF_W];
    assign bus.MemRead      = (state_q == ST_RD) || (state_q == ST_RMW_RD);
    assign bus.MemWrite     = (state_q == ST_WR) || (state_q == ST_RMW_MRG);
    assign bus.MemWriteData = req_q.write ? merge_word_c : '0;

endmodule
